park_counter: RTL and testbench
===============================

# park_counter

Occupancy counter for the parking-lot controller. Takes the raw entry-gate and exit-gate push-button/sensor inputs, synchronizes and debounces each, and converts it to a single-cycle event. It keeps the count of free spaces and publishes it as `remain` to the 4-digit display driver. It also flags full and empty lot conditions and refused events.

## Interface
- `CAPACITY`, 12, number of spaces; reset value of `remain`; legal range 1..15.
- `DB_LEN`, 4, consecutive stable cycles needed before a debounced level changes (only with `PARK_DEBOUNCE_EN`).
- `clk` input 1: single clock; all state on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_entry` input 1: raw, asynchronous entry request; high = car entering.
- `btn_exit` input 1: raw, asynchronous exit request; high = car leaving.
- `remain` output 4: free spaces, 0..CAPACITY, registered.
- `full` output 1: `remain == 0`, decoded from the registered `remain`.
- `empty` output 1: `remain == CAPACITY`, decoded from the registered `remain`.
- `reject` output 1: registered one-cycle pulse; an event was refused.

## Operation
- Each button path has four stages:
  - 2-flop synchronizer.
  - Debounce filter.
  - Rising-edge one-pulse: `ev` is high for exactly one cycle per 0→1 of the debounced level.
  - Counter update.
- Filter per path:
  - Holds a candidate level and a stable-cycle counter of width clog2(DB_LEN+1).
  - If the synchronized input differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DB_LEN, the debounced level flips and the counter clears.
  - Any glitch shorter than DB_LEN cycles causes no change.
- Counter update, with both events judged against the pre-update `remain`:
  - entry accepted iff `remain != 0`: remain−1.
  - exit accepted iff `remain != CAPACITY`: remain+1.
  - Both events in the same cycle and both accepted: net zero, `remain` unchanged, no reject.
  - Both events at `remain == 0`: entry refused, exit accepted; `remain` becomes 1, `reject` pulses.
  - Both events at `remain == CAPACITY`: exit refused, entry accepted; `remain` becomes CAPACITY−1, `reject` pulses.
  - Any refused event: `remain` unchanged by that event, `reject` = 1 for one cycle.
- Arithmetic is 4-bit unsigned. The guards above make wrap-around impossible: `remain` never leaves 0..CAPACITY.
- A held button generates exactly one event. Release then re-press is required for the next event.

## Timing
- Reset values:
  - `remain` = CAPACITY, `full` = 0, `empty` = 1, `reject` = 0.
  - Synchronizers, debounced levels, stable counters and pending pulses all cleared to 0.
- Latency with `PARK_DEBOUNCE_EN`:
  - Edge 0 is the first rising edge that samples the button high.
  - `remain`/`reject` update at edge DB_LEN+3, provided the input stays high throughout.
- Latency without `PARK_DEBOUNCE_EN`: update at edge 3.
- Release is filtered the same way. No event is generated on release.
- Reset mid-operation:
  - Any in-flight filter count or pulse is discarded.
  - A button still high when `rst` falls is seen as a fresh press and yields one event at the normal latency after reset release.

## Configuration
- `PARK_DEBOUNCE_EN` defined: full debounce filter per path, latency DB_LEN+3.
- `PARK_DEBOUNCE_EN` undefined:
  - The filter is omitted; debounced level = synchronizer output; latency 3.
  - `DB_LEN` is ignored.
  - Every clean rising edge of the synchronized input is an event.

## Structure
- Shared package `park_pkg`:
  - `PARK_CAPACITY_DEF` = 12.
  - `REMAIN_W` = 4.
  - `remain_t` typedef (logic [REMAIN_W-1:0]), also used by the display driver.
- Sub-module `btn_cond`: synchronizer + optional filter + one-pulse.
  - Ports: `clk`, `rst`, `din`, `ev`.
  - Instantiated once per button.
  - `park_counter` holds only the counter, decodes and reject logic.

## Test plan
- Reset, then DB_LEN=4, single clean `btn_entry` press held 10 cycles → `remain` 12→11 at edge 7, exactly one change, `empty` falls, `reject` stays 0.
- `btn_exit` glitch high for 3 cycles (< DB_LEN) with remain=11 → no change. Then a clean press → `remain`=12, `empty`=1.
- From `remain`=12, 12 clean entry presses → `remain`=0, `full`=1. A 13th entry → `remain` stays 0, `reject` pulses one cycle.
- Entry and exit events in the same cycle:
  - At `remain`=5 → stays 5, no reject.
  - At `remain`=0 → becomes 1, reject = 1.
  - At `remain`=12 → becomes 11, reject = 1.
- Exit press at `remain`=12 → stays 12, `reject` pulses, `empty` stays 1.
- Assert `rst` mid-filter with entry held high, release `rst` at `remain`=3 → `remain`=12 after reset, then 11 at edge DB_LEN+3 after release. Repeat with `PARK_DEBOUNCE_EN` undefined → update at edge 3.

Source files
------------

// File: rtl/park_pkg.sv
// Shared types and helpers for the parking-lot controller.
// The counter uses them, and so does the display driver (remain_t).
package park_pkg;

    localparam int PARK_CAPACITY_DEF = 12;
    localparam int REMAIN_W          = 4;

    typedef logic [REMAIN_W-1:0] remain_t;

    localparam remain_t REMAIN_ZERO = {REMAIN_W{1'b0}};
    localparam remain_t REMAIN_ONE  = {{(REMAIN_W-1){1'b0}}, 1'b1};

    // The caller's guards keep the result inside 0..capacity.
    // Simultaneous accepted inc/dec cancel.
    function automatic remain_t remain_step(input remain_t cur, input logic dec, input logic inc);
        remain_t nxt;
        nxt = cur;
        if (dec && !inc) begin
            nxt = cur - REMAIN_ONE;
        end else if (inc && !dec) begin
            nxt = cur + REMAIN_ONE;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce filter and a
// registered rising-edge one-pulse. The filter is built only when PARK_DEBOUNCE_EN is defined.
module btn_cond
    import park_pkg::*;
#(
    parameter int DB_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic ev
);

    logic sync1_q;
    logic sync2_q;
    logic level_s;
    logic prev_q;
    logic ev_q;

    if (DB_LEN < 1) begin : g_bad_db_len
        $error("btn_cond: DB_LEN must be at least 1");
    end

`ifdef PARK_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // The level flips on the DB_LEN-th consecutive cycle of disagreement.
    always_comb begin
        level_d = level_q;
        cnt_d   = {CNT_W{1'b0}};
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= {CNT_W{1'b0}};
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_s = level_q;
`else
    assign level_s = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            ev_q    <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= level_s;
            ev_q    <= level_s & ~prev_q;
        end
    end

    assign ev = ev_q;

endmodule

// File: rtl/park_counter.sv
// Parking-lot occupancy counter: conditioned entry/exit events drive a guarded
// count of free spaces. Debounce latency is selected by PARK_DEBOUNCE_EN.
module park_counter
    import park_pkg::*;
#(
    parameter int CAPACITY = PARK_CAPACITY_DEF,
    parameter int DB_LEN   = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    btn_entry,
    input  logic    btn_exit,
    output remain_t remain,
    output logic    full,
    output logic    empty,
    output logic    reject
);

    localparam remain_t CAP_V = remain_t'(CAPACITY);

    if (CAPACITY < 1 || CAPACITY > 15) begin : g_bad_capacity
        $error("park_counter: CAPACITY must be in 1..15");
    end

    logic    ev_entry_s;
    logic    ev_exit_s;
    logic    entry_ok_s;
    logic    exit_ok_s;
    remain_t remain_q;
    remain_t remain_d;
    logic    reject_q;
    logic    reject_d;

    btn_cond #(.DB_LEN(DB_LEN)) u_entry (
        .clk (clk),
        .rst (rst),
        .din (btn_entry),
        .ev  (ev_entry_s)
    );

    btn_cond #(.DB_LEN(DB_LEN)) u_exit (
        .clk (clk),
        .rst (rst),
        .din (btn_exit),
        .ev  (ev_exit_s)
    );

    // Both events are judged against the count before this update.
    always_comb begin
        entry_ok_s = ev_entry_s && (remain_q != REMAIN_ZERO);
        exit_ok_s  = ev_exit_s && (remain_q != CAP_V);
        remain_d   = remain_step(remain_q, entry_ok_s, exit_ok_s);
        reject_d   = (ev_entry_s && !entry_ok_s) || (ev_exit_s && !exit_ok_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remain_q <= CAP_V;
            reject_q <= 1'b0;
        end else begin
            remain_q <= remain_d;
            reject_q <= reject_d;
        end
    end

    assign remain = remain_q;
    assign reject = reject_q;
    assign full   = (remain_q == REMAIN_ZERO);
    assign empty  = (remain_q == CAP_V);

endmodule

// File: tb/tb_park_counter.sv
// Self-checking bench for park_counter: directed table, corner sequences and
// random stimulus against a window-based behavioural model.
module tb_park_counter;

    localparam int CAP = 12;
    localparam int DB  = 4;
`ifdef PARK_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = DB + 3;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 3;
`endif
    localparam int HOLD  = LAT + 3;
    localparam int HN    = DB + 4;
    localparam int N_OPS = 36;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_entry;
    logic       btn_exit;
    logic [3:0] remain;
    logic       full;
    logic       empty;
    logic       reject;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: raw-sample history, debounced levels, due times of events.
    int   m_rem = CAP;
    logic m_rej = 1'b0;
    logic m_lvl_e = 1'b0;
    logic m_lvl_x = 1'b0;
    logic hist_e[$];
    logic hist_x[$];
    int   due_e[$];
    int   due_x[$];
    int   tick = 0;

    typedef struct {
        logic e;
        logic x;
        int   exp_rem;
        int   exp_rej;
    } op_t;

    op_t tbl[N_OPS];
    int  n_tbl = 0;

    park_counter #(.CAPACITY(CAP), .DB_LEN(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_entry (btn_entry),
        .btn_exit  (btn_exit),
        .remain    (remain),
        .full      (full),
        .empty     (empty),
        .reject    (reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // h[j] is the raw level sampled j edges ago; the synchronizer shows it two edges late.
    function automatic logic next_level(input logic h[$], input logic lvl);
`ifdef PARK_DEBOUNCE_EN
        logic flip;
        flip = 1'b1;
        for (int j = 2; j <= DB + 1; j++) begin
            if (h[j] == lvl) flip = 1'b0;
        end
        return flip ? ~lvl : lvl;
`else
        return h[1];
`endif
    endfunction

    task automatic model_step(input logic r, input logic e, input logic x);
        logic ev_e, ev_x, acc_e, acc_x, nl;
        if (r) begin
            m_rem = CAP;
            m_rej = 1'b0;
            m_lvl_e = 1'b0;
            m_lvl_x = 1'b0;
            due_e.delete();
            due_x.delete();
            hist_e.delete();
            hist_x.delete();
            for (int j = 0; j < HN; j++) begin
                hist_e.push_back(1'b0);
                hist_x.push_back(1'b0);
            end
        end else begin
            ev_e = (due_e.size() > 0) && (due_e[0] == tick);
            ev_x = (due_x.size() > 0) && (due_x[0] == tick);
            if (ev_e) void'(due_e.pop_front());
            if (ev_x) void'(due_x.pop_front());
            acc_e = ev_e && (m_rem > 0);
            acc_x = ev_x && (m_rem < CAP);
            m_rem = m_rem - int'(acc_e) + int'(acc_x);
            m_rej = (ev_e && !acc_e) || (ev_x && !acc_x);
            hist_e.push_front(e);
            hist_x.push_front(x);
            void'(hist_e.pop_back());
            void'(hist_x.pop_back());
            nl = next_level(hist_e, m_lvl_e);
            if (nl && !m_lvl_e) due_e.push_back(tick + 2);
            m_lvl_e = nl;
            nl = next_level(hist_x, m_lvl_x);
            if (nl && !m_lvl_x) due_x.push_back(tick + 2);
            m_lvl_x = nl;
        end
        tick++;
    endtask

    // One clock: drive at negedge, model the posedge, compare at the next negedge.
    task automatic cycle(input logic e, input logic x, input logic r);
        btn_entry = e;
        btn_exit  = x;
        rst       = r;
        @(posedge clk);
        model_step(r, e, x);
        @(negedge clk);
        check("cyc_remain", int'(remain), m_rem);
        check("cyc_full", int'(full), int'(m_rem == 0));
        check("cyc_empty", int'(empty), int'(m_rem == CAP));
        check("cyc_reject", int'(reject), int'(m_rej));
    endtask

    task automatic op(input logic e, input logic x, input int exp_rem, input int exp_rej, input string name);
        int pulses;
        pulses = 0;
        repeat (HOLD) begin
            cycle(e, x, 1'b0);
            pulses += int'(reject);
        end
        repeat (HOLD) begin
            cycle(1'b0, 1'b0, 1'b0);
            pulses += int'(reject);
        end
        check({name, "_remain"}, int'(remain), exp_rem);
        check({name, "_rejects"}, pulses, exp_rej);
    endtask

    task automatic add(input logic e, input logic x, input int rem, input int rej);
        tbl[n_tbl] = '{e: e, x: x, exp_rem: rem, exp_rej: rej};
        n_tbl++;
    endtask

    initial begin
        int         changes;
        int         rejects;
        logic [3:0] prev_r;
        logic       re;
        logic       rx;
        int         len;

        add(1'b0, 1'b1, CAP, 1);
        for (int i = 1; i <= CAP; i++) add(1'b1, 1'b0, CAP - i, 0);
        add(1'b1, 1'b0, 0, 1);
        add(1'b1, 1'b1, 1, 1);
        for (int i = 2; i <= 5; i++) add(1'b0, 1'b1, i, 0);
        add(1'b1, 1'b1, 5, 0);
        for (int i = 6; i <= CAP; i++) add(1'b0, 1'b1, i, 0);
        add(1'b1, 1'b1, CAP - 1, 1);
        for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, CAP - 1 - i, 0);

        rst = 1'b1;
        btn_entry = 1'b0;
        btn_exit = 1'b0;
        @(negedge clk);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        check("rst_remain", int'(remain), CAP);
        check("rst_full", int'(full), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_reject", int'(reject), 0);

        // Single clean entry press held 10 cycles; edge 0 is the first high sample.
        changes = 0;
        rejects = 0;
        prev_r = remain;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check("press_remain", int'(remain), (i >= LAT) ? CAP - 1 : CAP);
            if (remain !== prev_r) changes++;
            prev_r = remain;
            rejects += int'(reject);
        end
        repeat (HOLD) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (remain !== prev_r) changes++;
            prev_r = remain;
            rejects += int'(reject);
        end
        check("press_changes", changes, 1);
        check("press_empty", int'(empty), 0);
        check("press_rejects", rejects, 0);

        // Short exit glitch, then a clean exit press.
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        repeat (HOLD) cycle(1'b0, 1'b0, 1'b0);
        check("glitch_remain", int'(remain), DEB ? CAP - 1 : CAP);
        op(1'b0, 1'b1, CAP, DEB ? 0 : 1, "exit_after_glitch");
        check("exit_empty", int'(empty), 1);

        for (int i = 0; i < n_tbl; i++) begin
            op(tbl[i].e, tbl[i].x, tbl[i].exp_rem, tbl[i].exp_rej, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].exp_rem == 0));
            check($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].exp_rem == CAP));
        end

        // Reset while entry is held mid-filter at remain=3.
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b1);
        check("midrst_remain", int'(remain), CAP);
        check("midrst_reject", int'(reject), 0);
        for (int i = 0; i < LAT + 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check("post_rst_remain", int'(remain), (i >= LAT) ? CAP - 1 : CAP);
        end
        repeat (HOLD) cycle(1'b0, 1'b0, 1'b0);

        // Random bursts of varying length with rare resets.
        for (int b = 0; b < 80; b++) begin
            re = 1'($urandom_range(0, 1));
            rx = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            for (int c = 0; c < len; c++) begin
                cycle(re, rx, ($urandom_range(0, 99) == 0));
            end
        end
        repeat (HOLD) cycle(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
